// File: rtl/jtframe_sdram64_busarb.sv
// rtl/jtframe_sdram64_busarb.sv - SDRAM pin arbiter and auto-refresh sequencer for four bank controllers
module jtframe_sdram64_busarb #(
  parameter int RFSHCNT = 781,
  parameter int TRP     = 2,
  parameter int TRFC    = 6,
  parameter int NB      = 4
)(
  input  logic             clk,
  input  logic             rstn,
  input  logic             rfsh_en,
  input  logic [NB-1:0]    br,
  output logic [NB-1:0]    bg,
  input  logic [4*NB-1:0]  bank_cmd,
  input  logic [13*NB-1:0] bank_a,
  input  logic [NB-1:0]    bank_idle,
  output logic             help,
  output logic [NB-1:0]    set_prech,
  output logic             rfsh_busy,
  output logic [3:0]       sdram_cmd,
  output logic [12:0]      sdram_a,
  output logic [1:0]       sdram_ba
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam int         CW      = $clog2(RFSHCNT + 1);
  localparam int         WW      = 8;

  typedef enum logic [2:0] {RUN, DRAIN, WAIT_RP, REF, WAIT_RFC} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [2:0]    pend;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;

  logic          gnt_vld;
  logic [1:0]    gnt_idx;
  logic [1:0]    idx;
  logic [3:0]    sel_cmd;
  logic [12:0]   sel_a;
  logic [3:0]    fsm_cmd;
  logic          all_idle;
  logic          rfsh_tick;
  logic          rfsh_issue;

  assign all_idle   = &bank_idle;
  assign rfsh_tick  = rfsh_en && (cnt == '0);
  assign rfsh_issue = (state == REF);
  assign rfsh_busy  = (state != RUN);

  // Round-robin search starting at the pointer; grants only while running
  always_comb begin
    bg      = '0;
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    idx     = ptr;
    if (state == RUN) begin
      for (int i = 0; i < 4; i++) begin
        idx = ptr + 2'(i);
        if (!gnt_vld && br[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx;
        end
      end
    end
    if (gnt_vld) bg[gnt_idx] = 1'b1;
  end

  // Pick the winning bank's command and address
  always_comb begin
    sel_cmd = CMD_NOP;
    sel_a   = '0;
    for (int i = 0; i < NB; i++) begin
      if (gnt_idx == 2'(i)) begin
        sel_cmd = bank_cmd[4*i +: 4];
        sel_a   = bank_a[13*i +: 13];
      end
    end
  end

  // Command the refresh sequencer wants on the pins this cycle
  always_comb begin
    fsm_cmd = CMD_NOP;
    if (state == DRAIN && all_idle) fsm_cmd = CMD_PRE;
    if (state == REF)               fsm_cmd = CMD_REF;
  end

  // Refresh interval counter and pending-refresh tally
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt  <= CW'(RFSHCNT - 1);
      pend <= '0;
    end else begin
      if (rfsh_en) cnt <= (cnt == '0) ? CW'(RFSHCNT - 1) : cnt - CW'(1);
      if (rfsh_tick && !rfsh_issue) begin
        if (pend != 3'd7) pend <= pend + 3'd1;
      end else if (!rfsh_tick && rfsh_issue) begin
        pend <= pend - 3'd1;
      end
    end
  end

  // Advance the round-robin pointer past each granted bank
  always_ff @(posedge clk) begin
    if (!rstn) ptr <= '0;
    else if (gnt_vld) ptr <= gnt_idx + 2'd1;
  end

  // Refresh sequencer: halt banks, precharge all, then issue pending refreshes
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= RUN;
      help      <= 1'b0;
      set_prech <= '0;
      wcnt      <= '0;
    end else begin
      set_prech <= '0;
      case (state)
        RUN: begin
          if (pend != 3'd0) begin
            state <= DRAIN;
            help  <= 1'b1;
          end
        end
        DRAIN: begin
          if (all_idle) begin
            state     <= WAIT_RP;
            wcnt      <= WW'(TRP - 1);
            set_prech <= {NB{1'b1}};
          end
        end
        WAIT_RP: begin
          if (wcnt == '0) state <= REF;
          else            wcnt  <= wcnt - WW'(1);
        end
        REF: begin
          state <= WAIT_RFC;
          wcnt  <= WW'(TRFC - 1);
        end
        WAIT_RFC: begin
          if (wcnt == '0) begin
            if (pend != 3'd0) begin
              state <= REF;
            end else begin
              state <= RUN;
              help  <= 1'b0;
            end
          end else begin
            wcnt <= wcnt - WW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Registered pins: granted bank wins, otherwise the sequencer's command
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sdram_cmd <= CMD_NOP;
      sdram_a   <= '0;
      sdram_ba  <= '0;
    end else if (gnt_vld && sel_cmd != CMD_NOP) begin
      sdram_cmd <= sel_cmd;
      sdram_a   <= sel_a;
      sdram_ba  <= gnt_idx;
    end else begin
      sdram_cmd <= fsm_cmd;
      if (fsm_cmd != CMD_NOP) begin
        sdram_a  <= 13'h400;
        sdram_ba <= 2'd0;
      end
    end
  end

endmodule
